// File: rtl/pipelined_core_pkg.sv
`default_nettype none
// ============================================================================
// pipelined_core_pkg : opcodes, operand modes and instruction field layout
// Revision 1.0
// ============================================================================
package pipelined_core_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  localparam logic MODE_REG = 1'b0;
  localparam logic MODE_IMM = 1'b1;

  // Instruction word: {mode, op[2:0], rd_rs1[aw-1:0], rs2_imm[aw-1:0]}
  localparam int RS2_LSB = 0;

  function automatic int rd_lsb(input int aw);
    return aw;
  endfunction

  function automatic int op_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int mode_bit(input int aw);
    return 2 * aw + 3;
  endfunction

  function automatic int instr_w(input int aw);
    return 2 * aw + 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_alu.sv
`default_nettype none
// ============================================================================
// pipe_alu : combinational 8-op ALU, results wrap modulo 2^DATA_W
// Revision 1.0
// ============================================================================
module pipe_alu
  import pipelined_core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_INC:  result = a + DATA_W'(1);
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = b;
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_core.sv
`default_nettype none
// ============================================================================
// pipelined_core : 5-stage IF/ID/EX/MEM/WB integer pipeline with forwarding
// Revision 1.0
// ============================================================================
module pipelined_core
  import pipelined_core_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int NREGS     = 4,
  parameter  int RESET_VAL = 3,
  localparam int REG_AW    = $clog2(NREGS),
  localparam int INSTR_W   = instr_w(REG_AW)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               stall,
  output logic               commit_valid,
  output logic [REG_AW-1:0]  commit_idx,
  output logic [DATA_W-1:0]  commit_data,
  input  logic [REG_AW-1:0]  dbg_idx,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int RD_LSB   = rd_lsb(REG_AW);
  localparam int OP_LSB   = op_lsb(REG_AW);
  localparam int MODE_BIT = mode_bit(REG_AW);

  logic [DATA_W-1:0] rf [NREGS];

  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;

  logic               ex_valid;
  logic               ex_mode;
  logic [2:0]         ex_op;
  logic [REG_AW-1:0]  ex_rd;
  logic [REG_AW-1:0]  ex_rs2;
  logic [DATA_W-1:0]  ex_a;
  logic [DATA_W-1:0]  ex_b;

  logic               mem_valid;
  logic               mem_wr;
  logic [REG_AW-1:0]  mem_rd;
  logic [DATA_W-1:0]  mem_data;

  logic               wb_valid;
  logic               wb_wr;
  logic [REG_AW-1:0]  wb_rd;
  logic [DATA_W-1:0]  wb_data;

  logic               id_mode;
  logic [2:0]         id_op;
  logic [REG_AW-1:0]  id_rd;
  logic [REG_AW-1:0]  id_rs2;
  logic [DATA_W-1:0]  id_a;
  logic [DATA_W-1:0]  id_b;

  logic               wb_we;
  logic               mem_fwd;
  logic [DATA_W-1:0]  fwd_a;
  logic [DATA_W-1:0]  fwd_b;
  logic [DATA_W-1:0]  alu_res;

  assign instr_ready = ~stall;
  assign dbg_data    = rf[dbg_idx];

  assign wb_we   = wb_valid & wb_wr;
  assign mem_fwd = mem_valid & mem_wr;

  assign id_mode = if_instr[MODE_BIT];
  assign id_op   = if_instr[OP_LSB +: 3];
  assign id_rd   = if_instr[RD_LSB +: REG_AW];
  assign id_rs2  = if_instr[RS2_LSB +: REG_AW];

  // Register read with write-through from the WB stage writing this cycle
  always_comb begin
    id_a = rf[id_rd];
    if (wb_we && wb_rd == id_rd) id_a = wb_data;
    id_b = rf[id_rs2];
    if (wb_we && wb_rd == id_rs2) id_b = wb_data;
    if (id_mode == MODE_IMM) id_b = DATA_W'(id_rs2);
  end

  always_comb begin
    fwd_a = ex_a;
    if (mem_fwd && mem_rd == ex_rd)     fwd_a = mem_data;
    else if (wb_we && wb_rd == ex_rd)   fwd_a = wb_data;
    fwd_b = ex_b;
    if (ex_mode == MODE_REG) begin
      if (mem_fwd && mem_rd == ex_rs2)    fwd_b = mem_data;
      else if (wb_we && wb_rd == ex_rs2)  fwd_b = wb_data;
    end
  end

  pipe_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (ex_op),
    .a      (fwd_a),
    .b      (fwd_b),
    .result (alu_res)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_valid  <= 1'b0;
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      wb_valid  <= 1'b0;
      wb_wr     <= 1'b0;
    end else begin
      if (!stall) begin
        if_valid <= instr_valid;
        ex_valid <= if_valid;
      end
      mem_valid <= ex_valid & ~stall;
      mem_wr    <= ex_valid & ~stall & (ex_op != OP_NOP);
      wb_valid  <= mem_valid;
      wb_wr     <= mem_wr;
    end
  end

  // A held EX instruction keeps refreshing its operands so producers draining
  // out through WB during the stall are not lost.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if_instr <= instr;
      ex_mode  <= id_mode;
      ex_op    <= id_op;
      ex_rd    <= id_rd;
      ex_rs2   <= id_rs2;
      ex_a     <= id_a;
      ex_b     <= id_b;
    end else begin
      ex_a     <= fwd_a;
      ex_b     <= fwd_b;
    end
    mem_rd   <= ex_rd;
    mem_data <= alu_res;
    wb_rd    <= mem_rd;
    wb_data  <= mem_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= DATA_W'(RESET_VAL);
    end else if (wb_we) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      commit_valid <= 1'b0;
      commit_idx   <= '0;
      commit_data  <= '0;
    end else begin
      commit_valid <= wb_we;
      if (wb_we) begin
        commit_idx  <= wb_rd;
        commit_data <= wb_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_core.sv
`default_nettype none
// ============================================================================
// tb_pipelined_core : scoreboard bench against an architectural register model
// Revision 1.0
// ============================================================================
module tb_pipelined_core;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  instr = '0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        instr_ready;
  logic        commit_valid;
  logic [1:0]  commit_idx;
  logic [31:0] commit_data;
  logic [1:0]  dbg_idx = '0;
  logic [31:0] dbg_data;

  logic [7:0]  instr8 = '0;
  logic        instr_valid8 = 1'b0;
  logic        instr_ready8;
  logic        commit_valid8;
  logic [1:0]  commit_idx8;
  logic [7:0]  commit_data8;
  logic [1:0]  dbg_idx8 = '0;
  logic [7:0]  dbg_data8;

  pipelined_core dut (
    .clk(clk), .resetn(resetn), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stall(stall), .commit_valid(commit_valid),
    .commit_idx(commit_idx), .commit_data(commit_data), .dbg_idx(dbg_idx),
    .dbg_data(dbg_data)
  );

  pipelined_core #(.DATA_W(8)) dut8 (
    .clk(clk), .resetn(resetn), .instr(instr8), .instr_valid(instr_valid8),
    .instr_ready(instr_ready8), .stall(1'b0), .commit_valid(commit_valid8),
    .commit_idx(commit_idx8), .commit_data(commit_data8), .dbg_idx(dbg_idx8),
    .dbg_data(dbg_data8)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  q8[$];
  logic [31:0] mrf [4];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input bit mode, input int op, input int rd, input int rs2);
    return {mode, 3'(op), 2'(rd), 2'(rs2)};
  endfunction

  // Architectural effect of one instruction, in program order
  task automatic model_accept(input logic [7:0] ins, input bit lat);
    logic [2:0]  op;
    logic [1:0]  rd;
    logic [31:0] a, b, r;
    op = ins[6:4];
    rd = ins[3:2];
    a  = mrf[rd];
    b  = ins[7] ? {30'd0, ins[1:0]} : mrf[ins[1:0]];
    case (op)
      3'd1:    r = a + b;
      3'd2:    r = a - b;
      3'd3:    r = a + 1;
      3'd4:    r = a & b;
      3'd5:    r = a | b;
      3'd6:    r = a ^ b;
      3'd7:    r = b;
      default: r = a;
    endcase
    if (op != 3'd0) begin
      mrf[rd] = r;
      sb_q.push_back('{idx: rd, data: r, acc: cyc, lat: lat});
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] ins, input bit s, input bit lat);
    @(negedge clk);
    instr = ins;
    instr_valid = v;
    stall = s;
    if (v && !s) model_accept(ins, lat);
    #1 chk("instr_ready", instr_ready, !s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic dbg_check();
    idle(6);
    chk("sb_drained", sb_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      dbg_idx = 2'(i);
      #1 chk("dbg_rf", dbg_data, mrf[i]);
    end
  endtask

  task automatic reset_model();
    sb_q.delete();
    q8.delete();
    for (int i = 0; i < 4; i++) mrf[i] = 32'd3;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    reset_model();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drive8(input logic [7:0] ins, input logic [7:0] exp);
    @(negedge clk);
    instr8 = ins;
    instr_valid8 = 1'b1;
    q8.push_back(exp);
  endtask

  always @(negedge clk) begin
    if (resetn && commit_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_commit", commit_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("commit_idx", commit_idx, e.idx);
        chk("commit_data", commit_data, e.data);
        if (e.lat) chk("commit_latency", cyc - e.acc, 5);
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && commit_valid8) begin
      if (q8.size() == 0) chk("unexpected_commit8", commit_valid8, 1'b0);
      else begin
        logic [7:0] e8;
        e8 = q8.pop_front();
        chk("commit8_idx", commit_idx8, 2'd0);
        chk("commit8_data", commit_data8, e8);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_model();
    // Reset state
    repeat (2) @(negedge clk);
    #1 chk("rst_commit_valid", commit_valid, 1'b0);
    chk("rst_commit_idx", commit_idx, 2'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    stall = 1'b1;
    #1 chk("rst_ready_follows_stall", instr_ready, 1'b0);
    stall = 1'b0;
    #1 chk("rst_ready_follows_stall", instr_ready, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    idle(8);
    dbg_check();

    // Back-to-back dependent chain with fixed latency
    drive(1'b1, enc(0, 1, 0, 1), 1'b0, 1'b1);
    drive(1'b1, enc(0, 3, 0, 0), 1'b0, 1'b1);
    drive(1'b1, enc(0, 1, 1, 0), 1'b0, 1'b1);
    dbg_check();

    // Immediate and register operand modes
    pulse_reset();
    drive(1'b1, enc(1, 2, 2, 1), 1'b0, 1'b1);
    drive(1'b1, enc(1, 6, 3, 2), 1'b0, 1'b1);
    drive(1'b1, enc(1, 7, 0, 3), 1'b0, 1'b1);
    drive(1'b1, enc(0, 2, 2, 3), 1'b0, 1'b1);
    dbg_check();

    // Stall for 3 cycles behind a dependent pair; a pending valid must not be taken
    pulse_reset();
    drive(1'b1, enc(0, 1, 0, 1), 1'b0, 1'b0);
    drive(1'b1, enc(0, 3, 0, 0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, enc(0, 1, 3, 3), 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    dbg_check();

    // 8-bit datapath wraparound
    drive8(enc(1, 2, 0, 3), 8'h00);
    drive8(enc(1, 2, 0, 1), 8'hFF);
    drive8(enc(0, 3, 0, 0), 8'h00);
    @(negedge clk);
    instr_valid8 = 1'b0;
    repeat (6) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    dbg_idx8 = 2'd0;
    #1 chk("dbg8_r0", dbg_data8, 8'h00);

    // Asynchronous reset while instructions are in flight and one is committing
    drive(1'b1, enc(0, 1, 0, 1), 1'b0, 1'b0);
    drive(1'b1, enc(0, 3, 1, 1), 1'b0, 1'b0);
    drive(1'b1, enc(1, 6, 2, 3), 1'b0, 1'b0);
    drive(1'b1, enc(0, 7, 3, 0), 1'b0, 1'b0);
    drive(1'b1, enc(1, 1, 0, 2), 1'b0, 1'b0);
    @(posedge clk);
    #3;
    instr_valid = 1'b0;
    resetn = 1'b0;
    reset_model();
    #1 chk("async_rst_commit_valid", commit_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dbg_idx = 2'(i);
      #1 chk("async_rst_rf", dbg_data, 32'd3);
    end
    @(posedge clk);
    #3 resetn = 1'b1;
    idle(8);
    dbg_check();

    // Randomized traffic with bubbles and stalls
    for (int n = 0; n < 400; n++) begin
      bit v, s;
      v = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 3) == 0);
      drive(v, 8'($urandom), s, 1'b0);
    end
    dbg_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
